// File: rtl/sq_integral_cache_gen.sv
// Integral-image builder: streams a raster frame in and stores plain or squared prefix sums in a blocked RAM.
// Optional build macro SQC_SATURATE_EN clamps overflowing sums to all-ones instead of wrapping.
module sq_integral_cache_gen #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int PIX_W    = 8,
    parameter int WORD_W   = 33,
    parameter int BLOCKING = 4,
    parameter int MODE     = 1,
    localparam int BLOCKS  = (IMG_W + BLOCKING) / BLOCKING,
    localparam int XB_W    = (BLOCKS > 1) ? $clog2(BLOCKS) : 1,
    localparam int Y_W     = (IMG_H > 0) ? $clog2(IMG_H + 1) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         frame_done,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [PIX_W-1:0]             pix_data,
    output logic                         overflow,
    input  logic                         rd_en,
    input  logic [Y_W-1:0]               rd_y,
    input  logic [XB_W-1:0]              rd_xblock,
    output logic [BLOCKING*WORD_W-1:0]   rd_q,
    output logic                         rd_valid
);

    localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int P_W   = (MODE != 0) ? 2 * PIX_W : PIX_W;
    localparam int S_W   = ((WORD_W > P_W) ? WORD_W : P_W) + 1;
    localparam int DEPTH = (IMG_H + 1) * BLOCKS;
    localparam int A_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        DONE
    } state_t;

    state_t state, state_next;

    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic [XB_W-1:0]   clr_blk;
    logic [WORD_W-1:0] rowsum;

    logic [WORD_W-1:0]                 line [IMG_W];
    logic [BLOCKING-1:0][WORD_W-1:0]   mem  [DEPTH];

    logic accept, x_last, y_last;

    assign accept = (state == STREAM) && pix_valid;
    assign x_last = (x_cnt == X_W'(IMG_W - 1));
    assign y_last = (y_cnt == Y_W'(IMG_H - 1));

    assign busy       = (state != IDLE);
    assign pix_ready  = (state == STREAM);
    assign frame_done = (state == DONE);

    // Reduce a widened sum to a stored word; anything above WORD_W bits is an overflow.
    function automatic logic [WORD_W-1:0] clip(input logic [S_W-1:0] s);
`ifdef SQC_SATURATE_EN
        return (|s[S_W-1:WORD_W]) ? {WORD_W{1'b1}} : s[WORD_W-1:0];
`else
        return s[WORD_W-1:0];
`endif
    endfunction

    logic [S_W-1:0]    p_ext, rs_sum, v_sum;
    logic [WORD_W-1:0] rs_val, v_val, line_base;
    logic              sum_ovf;

    // NOTE: every signal driven here gets a value on entry, so no path can leave it holding and infer a latch.
    always_comb begin
        p_ext     = (MODE != 0) ? S_W'(pix_data) * S_W'(pix_data) : S_W'(pix_data);
        rs_sum    = p_ext + ((x_cnt == '0) ? '0 : S_W'(rowsum));
        rs_val    = clip(rs_sum);
        line_base = (y_cnt == '0) ? '0 : line[x_cnt];
        v_sum     = S_W'(rs_val) + S_W'(line_base);
        v_val     = clip(v_sum);
        sum_ovf   = (|rs_sum[S_W-1:WORD_W]) | (|v_sum[S_W-1:WORD_W]);
    end

    logic                            wr_en;
    logic [A_W-1:0]                  wr_addr;
    logic [BLOCKING-1:0]             wr_mask;
    logic [BLOCKING-1:0][WORD_W-1:0] wr_data;

    // One block per cycle: the new word plus column 0 at row start or the padding lanes at row end.
    always_comb begin
        int col;
        int blk;
        int c;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_mask = '0;
        wr_data = '0;
        col     = int'(x_cnt) + 1;
        blk     = col / BLOCKING;
        c       = 0;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = A_W'(clr_blk);
            wr_mask = '1;
        end else if (accept) begin
            wr_en   = 1'b1;
            wr_addr = A_W'((int'(y_cnt) + 1) * BLOCKS + blk);
            for (int k = 0; k < BLOCKING; k++) begin
                c = blk * BLOCKING + k;
                if (c == col) begin
                    wr_mask[k] = 1'b1;
                    wr_data[k] = v_val;
                end else if ((c == 0 && x_cnt == '0) || (c > IMG_W && x_last)) begin
                    wr_mask[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   if (clr_blk == XB_W'(BLOCKS - 1)) state_next = STREAM;
            STREAM:  if (accept && x_last && y_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            clr_blk  <= '0;
            rowsum   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        clr_blk  <= '0;
                        overflow <= 1'b0;
                    end
                end
                CLEAR: clr_blk <= clr_blk + 1'b1;
                STREAM: begin
                    if (accept) begin
                        rowsum <= rs_val;
                        if (sum_ovf) overflow <= 1'b1;
                        if (x_last) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; their contents are only meaningful once rebuilt by a frame.
    always_ff @(posedge clk) begin
        if (accept) line[x_cnt] <= v_val;
        if (wr_en) begin
            for (int k = 0; k < BLOCKING; k++) begin
                if (wr_mask[k]) mem[wr_addr][k] <= wr_data[k];
            end
        end
    end

    logic [A_W-1:0] rd_addr;
    assign rd_addr = A_W'(int'(rd_y) * BLOCKS + int'(rd_xblock));

    // Registered read sees the array before any same-edge write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_q     <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_q <= mem[rd_addr];
        end
    end

endmodule
